// File: rtl/spi_ram_arbiter_if.sv
// Bundled handshake and SPI bus for spi_ram_arbiter.
// Groups the two requester channels, the SPI master control/status signals
// and the response channel. The slave modport is the arbiter's view; the
// master modport is the view of whatever drives the requests and models SPI.
interface spi_ram_arbiter_if #(
   parameter int ADDR_SIZE = 8
);
   // Requester A
   logic                   req_valid_a;
   logic                   req_ready_a;
   logic                   req_wr_a;
   logic [ADDR_SIZE-1:0]   req_addr_a;
   logic [ADDR_SIZE-1:0]   req_data_a;
   // Requester B
   logic                   req_valid_b;
   logic                   req_ready_b;
   logic                   req_wr_b;
   logic [ADDR_SIZE-1:0]   req_addr_b;
   logic [ADDR_SIZE-1:0]   req_data_b;
   // SPI master / RAM wrapper
   logic                   spi_startTx;
   logic                   spi_startRx;
   logic                   spi_which_slave;
   logic [2*ADDR_SIZE-1:0] spi_din;
   logic                   spi_tx_done;
   logic                   spi_rx_done;
   logic [2*ADDR_SIZE-1:0] spi_rx_data;
   // Response channel
   logic                   rsp_valid;
   logic                   rsp_owner;
   logic [ADDR_SIZE-1:0]   rsp_data;
   logic                   rsp_err;

   modport slave (
      input  req_valid_a, req_wr_a, req_addr_a, req_data_a,
      input  req_valid_b, req_wr_b, req_addr_b, req_data_b,
      output req_ready_a, req_ready_b,
      output spi_startTx, spi_startRx, spi_which_slave, spi_din,
      input  spi_tx_done, spi_rx_done, spi_rx_data,
      output rsp_valid, rsp_owner, rsp_data, rsp_err
   );

   modport master (
      output req_valid_a, req_wr_a, req_addr_a, req_data_a,
      output req_valid_b, req_wr_b, req_addr_b, req_data_b,
      input  req_ready_a, req_ready_b,
      input  spi_startTx, spi_startRx, spi_which_slave, spi_din,
      output spi_tx_done, spi_rx_done, spi_rx_data,
      input  rsp_valid, rsp_owner, rsp_data, rsp_err
   );
endinterface

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: round-robin sequencer sharing one SPI master + dual-port
// RAM datapath between requesters A and B. One command is in flight at a
// time: IDLE (arbitrate) -> LAUNCH (start strobe) -> WAIT (done/timeout)
// -> RESP (one-cycle response strobe).
// Optional build macro SPI_ARB_STATS_EN adds saturating grant/timeout
// statistics outputs; without it those ports and counters do not exist.
module spi_ram_arbiter #(
   parameter int ADDR_SIZE = 8,
   parameter int TIMEOUT   = 64,   // WAIT cycles before abort, >= 2
   parameter int TO_W      = 7     // 2**TO_W > TIMEOUT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   spi_ram_arbiter_if.slave     bus
`ifdef SPI_ARB_STATS_EN
   ,
   output logic [15:0]          stat_grants_a,
   output logic [15:0]          stat_grants_b,
   output logic [15:0]          stat_timeouts
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam logic OWNER_A = 1'b0;
   localparam logic OWNER_B = 1'b1;

   state_t               state;
   logic                 last_grant;   // owner of the most recent handshake
   logic                 op_wr;        // operation of the command in flight
   logic                 op_owner;     // owner of the command in flight
   logic [TO_W-1:0]      to_cnt;

   logic                 grant_a;
   logic                 grant_b;
   logic                 hs_a;
   logic                 hs_b;
   logic                 sel_wr;
   logic [ADDR_SIZE-1:0] sel_addr;
   logic [ADDR_SIZE-1:0] sel_data;
   logic                 done_hit;
   logic                 to_expired;

   // Only the read-data half of the received frame matters here.
   logic                 rx_lo_unused;
   assign rx_lo_unused = ^bus.spi_rx_data[ADDR_SIZE-1:0];

   // Round-robin: on contention the requester that did not win last time wins.
   assign grant_a = bus.req_valid_a && (!bus.req_valid_b || (last_grant == OWNER_B));
   assign grant_b = bus.req_valid_b && (!bus.req_valid_a || (last_grant == OWNER_A));

   // Ready is forced low while reset is asserted so every output reads 0.
   assign bus.req_ready_a = rst_n && (state == ST_IDLE) && grant_a;
   assign bus.req_ready_b = rst_n && (state == ST_IDLE) && grant_b;

   assign hs_a = bus.req_valid_a && bus.req_ready_a;
   assign hs_b = bus.req_valid_b && bus.req_ready_b;

   assign done_hit   = op_wr ? bus.spi_tx_done : bus.spi_rx_done;
   assign to_expired = (to_cnt == TO_W'(TIMEOUT - 1));

   // Select the fields of whichever requester is being accepted this cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      sel_wr   = bus.req_wr_b;
      sel_addr = bus.req_addr_b;
      sel_data = bus.req_data_b;
      if (hs_a) begin
         sel_wr   = bus.req_wr_a;
         sel_addr = bus.req_addr_a;
         sel_data = bus.req_data_a;
      end
   end

   // Transaction FSM with all SPI and response outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
         state               <= ST_IDLE;
         last_grant          <= OWNER_B;
         op_wr               <= 1'b0;
         op_owner            <= OWNER_A;
         to_cnt              <= '0;
         bus.spi_startTx     <= 1'b0;
         bus.spi_startRx     <= 1'b0;
         bus.spi_which_slave <= 1'b0;
         bus.spi_din         <= '0;
         bus.rsp_valid       <= 1'b0;
         bus.rsp_owner       <= 1'b0;
         bus.rsp_data        <= '0;
         bus.rsp_err         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (hs_a || hs_b) begin
                  op_wr               <= sel_wr;
                  op_owner            <= hs_a ? OWNER_A : OWNER_B;
                  last_grant          <= hs_a ? OWNER_A : OWNER_B;
                  bus.spi_startTx     <= sel_wr;
                  bus.spi_startRx     <= !sel_wr;
                  bus.spi_which_slave <= hs_a;
                  bus.spi_din         <= sel_wr ? {sel_data, sel_addr}
                                                : {{ADDR_SIZE{1'b0}}, sel_addr};
                  state               <= ST_LAUNCH;
               end
            end

            ST_LAUNCH: begin
               bus.spi_startTx <= 1'b0;
               bus.spi_startRx <= 1'b0;
               to_cnt          <= '0;
               state           <= ST_WAIT;
            end

            ST_WAIT: begin
               // A matching done beats a simultaneous timeout expiry.
               if (done_hit) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_owner <= op_owner;
                  bus.rsp_err   <= 1'b0;
                  bus.rsp_data  <= op_wr ? '0
                                         : bus.spi_rx_data[2*ADDR_SIZE-1:ADDR_SIZE];
                  state         <= ST_RESP;
               end else if (to_expired) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_owner <= op_owner;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_data  <= '0;
                  state         <= ST_RESP;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end

            ST_RESP: begin
               bus.rsp_valid <= 1'b0;
               state         <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef SPI_ARB_STATS_EN
   logic timeout_hit;
   assign timeout_hit = (state == ST_WAIT) && !done_hit && to_expired;

   // Saturating statistics counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_grants_a <= '0;
         stat_grants_b <= '0;
         stat_timeouts <= '0;
      end else begin
         if (hs_a && (stat_grants_a != 16'hFFFF)) stat_grants_a <= stat_grants_a + 16'd1;
         if (hs_b && (stat_grants_b != 16'hFFFF)) stat_grants_b <= stat_grants_b + 16'd1;
         if (timeout_hit && (stat_timeouts != 16'hFFFF)) stat_timeouts <= stat_timeouts + 16'd1;
      end
   end
`endif

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Sequences and shares the SPI master + dual-port RAM datapath between two requesters, A and B.
- Accepts write/read commands via valid/ready handshakes and arbitrates them round-robin.
- Drives the SPI start strobes, slave select and 16-bit frame, then waits for done or a timeout.
- Returns one response per command. Sits directly above the SPI/RAM wrapper.

Parameters:
- ADDR_SIZE, 8, address and data width; SPI frame is 2*ADDR_SIZE.
- TIMEOUT, 64, WAIT-state cycles before a transaction is aborted (must be >= 2).
- TO_W, 7, timeout counter width (must satisfy 2^TO_W > TIMEOUT).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_a / req_valid_b  in  1  command valid, requester A / B
- req_ready_a / req_ready_b  out  1  command accepted when valid&&ready
- req_wr_a / req_wr_b  in  1  1 = write, 0 = read
- req_addr_a / req_addr_b  in  ADDR_SIZE  RAM address
- req_data_a / req_data_b  in  ADDR_SIZE  write data
- spi_startTx  out  1  one-cycle write strobe
- spi_startRx  out  1  one-cycle read strobe
- spi_which_slave  out  1  1 = port A slave, 0 = port B slave
- spi_din  out  2*ADDR_SIZE  frame {data, addr}
- spi_tx_done  in  1  write complete
- spi_rx_done  in  1  read complete
- spi_rx_data  in  2*ADDR_SIZE  received frame; upper half = read data
- rsp_valid  out  1  one-cycle response strobe
- rsp_owner  out  1  0 = A, 1 = B
- rsp_data  out  ADDR_SIZE  read data (0 for writes and errors)
- rsp_err  out  1  timeout flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE; last_grant=B, so A wins first. All outputs 0. Timeout counter 0. Reset mid-transaction aborts silently with no response.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE, arbitration:
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the requester not in last_grant.
  - req_ready_x is combinational = (state==IDLE) && grant==x, so at most one ready is high.
  - On handshake: latch wr/addr/data/owner, update last_grant, go to LAUNCH.
- LAUNCH (1 cycle):
  - spi_startTx=wr or spi_startRx=!wr, asserted for exactly this cycle.
  - spi_din = wr ? {data,addr} : {0,addr}.
  - spi_which_slave = (owner==A).
  - Go to WAIT; timeout counter cleared.
- spi_din and spi_which_slave hold from LAUNCH through RESP, then hold their last value.
- WAIT:
  - Only the done matching the operation counts (tx_done for writes, rx_done for reads); the other is ignored.
  - Done is sampled only in WAIT; a done asserted during LAUNCH is ignored.
  - Matching done -> RESP with err=0. For reads, capture rsp_data = spi_rx_data[2*ADDR_SIZE-1:ADDR_SIZE].
  - Counter increments each WAIT cycle. When it reaches TIMEOUT-1 with no done -> RESP, err=1, rsp_data=0.
  - Done in the same cycle as the timeout expiry: done wins, err=0.
- RESP (1 cycle): rsp_valid=1 with owner/data/err stable; next state IDLE. rsp_* hold their values after rsp_valid drops.
- Latency: handshake at cycle T -> start strobe at T+1 -> done at D >= T+2 -> rsp_valid at D+1 -> next handshake possible at D+2.
- Requests arriving outside IDLE wait; valid must stay high until accepted.

Optional Feature:
- SPI_ARB_STATS_EN defined: adds outputs stat_grants_a[15:0], stat_grants_b[15:0], stat_timeouts[15:0].
  - Saturating counters, reset to 0.
  - Grant counters increment on each handshake; the timeout counter increments on entering RESP with err=1.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-WAIT -> all outputs 0 immediately, no rsp_valid. After release, A wins first contention.
- A write addr=0x12 data=0xA5, tx_done 3 cycles after strobe -> spi_din=0xA512, spi_startTx one cycle, which_slave=1; rsp_valid one cycle after done with owner=0, err=0, data=0.
- B read addr=0x34, rx_done with spi_rx_data=0x5C34 -> spi_startRx pulse, which_slave=0; rsp owner=1, data=0x5C, err=0.
- A and B held valid continuously for 4 commands -> grants A, B, A, B. Only one ready high per cycle.
- No done for TIMEOUT=64 WAIT cycles -> rsp_err=1, rsp_data=0, returns to IDLE. Done exactly on the expiry cycle -> err=0.
- Stray rx_done during a write WAIT, and a done during LAUNCH -> both ignored; completion only on tx_done.
